// File: rtl/wishbone_pipelined_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_gpio_pkg
// Description : Register map, bank stride and edge encodings for the
//               pipelined Wishbone GPIO.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_gpio_pkg;

    localparam logic [4:0] c_OFF_DATA_IN  = 5'h00;
    localparam logic [4:0] c_OFF_DATA_OUT = 5'h04;
    localparam logic [4:0] c_OFF_TRISTATE = 5'h08;
    localparam logic [4:0] c_OFF_IRQ_EN   = 5'h0C;
    localparam logic [4:0] c_OFF_IRQ_STAT = 5'h10;
    localparam logic [4:0] c_OFF_EDGE_SEL = 5'h14;
    localparam logic [4:0] c_OFF_DATA_SET = 5'h18;
    localparam logic [4:0] c_OFF_DATA_CLR = 5'h1C;

    localparam int c_BANK_STRIDE = 32'h20;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

    function automatic logic [31:0] bank_index(input logic [31:0] byte_addr);
        return byte_addr >> $clog2(c_BANK_STRIDE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wishbone_pipelined_gpio_if.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_pipelined_gpio_if
// Description : Wishbone B4 pipelined bus bundle with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface wishbone_pipelined_gpio_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 4
);
    logic                     cyc;
    logic                     stb;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [BUS_WIDTH*8-1:0]   data_i;
    logic [BUS_WIDTH-1:0]     sel;
    logic                     ack;
    logic                     err;
    logic                     stall;
    logic [BUS_WIDTH*8-1:0]   data_o;

    modport master (
        output cyc, stb, we, addr, data_i, sel,
        input  ack, err, stall, data_o
    );

    modport slave (
        input  cyc, stb, we, addr, data_i, sel,
        output ack, err, stall, data_o
    );
endinterface
`default_nettype wire

// File: rtl/wishbone_pipelined_gpio_bank_irq.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bank_irq
// Description : One bank's input synchroniser, edge detector and
//               IRQ_EN / IRQ_STATUS / EDGE_SEL registers.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bank_irq
    import wb_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int IRQ_ENABLE  = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [GPIO_WIDTH-1:0] pins,
    input  wire logic                  wr_irq_en,
    input  wire logic                  wr_edge_sel,
    input  wire logic                  wr_status,
    input  wire logic [GPIO_WIDTH-1:0] wr_data,
    input  wire logic [GPIO_WIDTH-1:0] wr_mask,
    output logic      [GPIO_WIDTH-1:0] sync_in,
    output logic      [GPIO_WIDTH-1:0] irq_en,
    output logic      [GPIO_WIDTH-1:0] edge_sel,
    output logic      [GPIO_WIDTH-1:0] status
);
    localparam logic c_IRQ_ON = (IRQ_ENABLE != 0);

    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync;
    logic [GPIO_WIDTH-1:0] r_prev, r_irq_en, r_edge_sel, r_status;
    logic [GPIO_WIDTH-1:0] w_rise, w_fall, w_set, w_clr;

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_fall = ~r_sync[SYNC_STAGES-1] & r_prev;
    assign w_clr  = wr_status ? (wr_data & wr_mask) : '0;

    always_comb begin
        w_set = '0;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            w_set[i] = c_IRQ_ON & r_irq_en[i] &
                       ((r_edge_sel[i] == EDGE_RISING) ? w_rise[i] : w_fall[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '0;
            r_prev     <= '0;
            r_irq_en   <= '0;
            r_edge_sel <= '0;
            r_status   <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pins};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (wr_irq_en)
                r_irq_en <= (r_irq_en & ~wr_mask) | (wr_data & wr_mask);
            if (wr_edge_sel)
                r_edge_sel <= (r_edge_sel & ~wr_mask) | (wr_data & wr_mask);
            // A new edge in the same cycle as its W1C keeps the bit set
            r_status <= (r_status & ~w_clr) | w_set;
        end
    end

    assign sync_in  = r_sync[SYNC_STAGES-1];
    assign irq_en   = c_IRQ_ON ? r_irq_en   : '0;
    assign edge_sel = c_IRQ_ON ? r_edge_sel : '0;
    assign status   = c_IRQ_ON ? r_status   : '0;
endmodule
`default_nettype wire

// File: rtl/wishbone_pipelined_gpio.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_pipelined_gpio
// Description : Multi-bank GPIO on a Wishbone B4 pipelined slave port.
//               Define WB_GPIO_ATOMIC_SET_CLR_EN for DATA_SET/DATA_CLR.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_pipelined_gpio
    import wb_gpio_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 4,
    parameter int GPIO_WIDTH    = 32,
    parameter int BANKS         = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int IRQ_ENABLE    = 1
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    wishbone_pipelined_gpio_if.slave         s_wb,
    output logic                             irq,
    input  wire logic [BANKS*GPIO_WIDTH-1:0] gpio_io_i,
    output logic      [BANKS*GPIO_WIDTH-1:0] gpio_io_o,
    output logic      [BANKS*GPIO_WIDTH-1:0] gpio_io_t
);
    localparam int c_DW = BUS_WIDTH * 8;
`ifdef WB_GPIO_ATOMIC_SET_CLR_EN
    localparam logic c_ATOMIC = 1'b1;
`else
    localparam logic c_ATOMIC = 1'b0;
`endif

    logic [ADDRESS_WIDTH-1:0]    w_addr;
    logic [4:0]                  w_off;
    logic [31:0]                 w_bank_idx;
    logic                        w_accept, w_err, w_wr;
    logic [c_DW-1:0]             w_lane_mask, w_rd_bus;
    logic [GPIO_WIDTH-1:0]       w_wmask, w_wdata, w_rd;
    logic [BANKS*GPIO_WIDTH-1:0] w_bank_rd, w_status;
    logic                        r_ack, r_err, r_irq;
    logic [c_DW-1:0]             r_rdata;

    assign s_wb.stall = 1'b0;
    assign w_addr     = s_wb.addr;
    assign w_off      = w_addr[4:0];
    assign w_bank_idx = bank_index(32'(w_addr));
    assign w_accept   = s_wb.cyc & s_wb.stb & ~s_wb.stall;
    assign w_wr       = w_accept & s_wb.we & ~w_err;

    always_comb begin
        w_err = 1'b0;
        if (w_addr[1:0] != 2'b00)
            w_err = 1'b1;
        else if (w_bank_idx >= BANKS)
            w_err = 1'b1;
        else if (!c_ATOMIC && w_off >= c_OFF_DATA_SET)
            w_err = 1'b1;
        else if (s_wb.we && w_off == c_OFF_DATA_IN)
            w_err = 1'b1;
    end

    for (genvar k = 0; k < BUS_WIDTH; k++) begin : g_lane
        assign w_lane_mask[k*8 +: 8] = {8{s_wb.sel[k]}};
    end
    assign w_wmask = w_lane_mask[GPIO_WIDTH-1:0];
    assign w_wdata = s_wb.data_i[GPIO_WIDTH-1:0];

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic                  w_hit;
        logic [GPIO_WIDTH-1:0] r_dout, r_tri, w_sync, w_irq_en, w_edge_sel, w_stat, w_rd_b;

        assign w_hit = w_wr && (w_bank_idx == 32'(b));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout <= '0;
                r_tri  <= '1;
            end else if (w_hit) begin
                case (w_off)
                    c_OFF_DATA_OUT: r_dout <= (r_dout & ~w_wmask) | (w_wdata & w_wmask);
                    c_OFF_TRISTATE: r_tri  <= (r_tri & ~w_wmask) | (w_wdata & w_wmask);
`ifdef WB_GPIO_ATOMIC_SET_CLR_EN
                    c_OFF_DATA_SET: r_dout <= r_dout | (w_wdata & w_wmask);
                    c_OFF_DATA_CLR: r_dout <= r_dout & ~(w_wdata & w_wmask);
`endif
                    default: ;
                endcase
            end
        end

        gpio_bank_irq #(
            .GPIO_WIDTH  (GPIO_WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .IRQ_ENABLE  (IRQ_ENABLE)
        ) u_irq (
            .clk         (clk),
            .rst         (rst),
            .pins        (gpio_io_i[b*GPIO_WIDTH +: GPIO_WIDTH]),
            .wr_irq_en   (w_hit && w_off == c_OFF_IRQ_EN),
            .wr_edge_sel (w_hit && w_off == c_OFF_EDGE_SEL),
            .wr_status   (w_hit && w_off == c_OFF_IRQ_STAT),
            .wr_data     (w_wdata),
            .wr_mask     (w_wmask),
            .sync_in     (w_sync),
            .irq_en      (w_irq_en),
            .edge_sel    (w_edge_sel),
            .status      (w_stat)
        );

        always_comb begin
            w_rd_b = '0;
            case (w_off)
                c_OFF_DATA_IN:  w_rd_b = w_sync;
                c_OFF_DATA_OUT: w_rd_b = r_dout;
                c_OFF_TRISTATE: w_rd_b = r_tri;
                c_OFF_IRQ_EN:   w_rd_b = w_irq_en;
                c_OFF_IRQ_STAT: w_rd_b = w_stat;
                c_OFF_EDGE_SEL: w_rd_b = w_edge_sel;
                default:        w_rd_b = '0;
            endcase
        end

        assign w_bank_rd[b*GPIO_WIDTH +: GPIO_WIDTH] = w_rd_b;
        assign w_status[b*GPIO_WIDTH +: GPIO_WIDTH]  = w_stat;
        assign gpio_io_o[b*GPIO_WIDTH +: GPIO_WIDTH] = r_dout;
        assign gpio_io_t[b*GPIO_WIDTH +: GPIO_WIDTH] = r_tri;
    end

    always_comb begin
        w_rd = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_bank_idx == 32'(b))
                w_rd = w_bank_rd[b*GPIO_WIDTH +: GPIO_WIDTH];
        end
        w_rd_bus = '0;
        w_rd_bus[GPIO_WIDTH-1:0] = w_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ack   <= w_accept & ~w_err;
            r_err   <= w_accept & w_err;
            r_rdata <= (w_accept && !s_wb.we && !w_err) ? w_rd_bus : '0;
            r_irq   <= |w_status;
        end
    end

    // Dropping cyc abandons the cycle, so the pending response is masked
    assign s_wb.ack    = r_ack & s_wb.cyc;
    assign s_wb.err    = r_err & s_wb.cyc;
    assign s_wb.data_o = (r_ack & s_wb.cyc) ? r_rdata : '0;
    assign irq         = r_irq;
endmodule
`default_nettype wire
